// File: rtl/rv32i_dport_arbiter_if.sv
// Signal bundle for the shared RAM data port: requester P, requester D and the RAM side.
// Defining DPORT_LOCK_EN adds the d_lock signal from the debug master.
interface rv32i_dport_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              p_req;
  logic              p_we;
  logic [3:0]        p_be;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_wdata;
  logic              p_stall;
  logic              p_rvalid;
  logic [31:0]       p_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

`ifdef DPORT_LOCK_EN
  logic              d_lock;

  modport slave (
    input  p_req, p_we, p_be, p_addr, p_wdata,
    output p_stall, p_rvalid, p_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    output d_gnt, d_rvalid, d_rdata,
    output ram_addr, ram_we, ram_be, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output p_req, p_we, p_be, p_addr, p_wdata,
    input  p_stall, p_rvalid, p_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_addr, ram_we, ram_be, ram_wdata,
    output ram_rdata
  );
`else
  modport slave (
    input  p_req, p_we, p_be, p_addr, p_wdata,
    output p_stall, p_rvalid, p_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_addr, ram_we, ram_be, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output p_req, p_we, p_be, p_addr, p_wdata,
    input  p_stall, p_rvalid, p_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_addr, ram_we, ram_be, ram_wdata,
    output ram_rdata
  );
`endif
endinterface

// File: rtl/rv32i_dport_arbiter.sv
// Arbiter sharing the RAM data port between the pipeline MEM stage (P) and a debug master (D).
// Optional macro DPORT_LOCK_EN adds a d_lock input that lets D hold the port exclusively.
module rv32i_dport_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  rv32i_dport_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PIPE, DBG, D_BURST} gnt_state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_P, TAG_D} rd_tag_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  gnt_state_e        last_gnt, last_gnt_nxt;
  rd_tag_e           rd_tag, rd_tag_nxt;
  logic [7:0]        starve_cnt, starve_cnt_nxt;
  logic              forced_q, forced_nxt;
  logic              g_p, g_d;
  logic              p_rvalid, d_rvalid;
  logic [ADDR_W-1:0] addr_mux;
`ifdef DPORT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
  lock_state_e       lock_st, lock_nxt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_gnt   <= IDLE;
      rd_tag     <= TAG_NONE;
      starve_cnt <= 8'd0;
      forced_q   <= 1'b0;
`ifdef DPORT_LOCK_EN
      lock_st    <= UNLOCKED;
`endif
    end else begin
      last_gnt   <= last_gnt_nxt;
      rd_tag     <= rd_tag_nxt;
      starve_cnt <= starve_cnt_nxt;
      forced_q   <= forced_nxt;
`ifdef DPORT_LOCK_EN
      lock_st    <= lock_nxt;
`endif
    end
  end

  // Next-state logic; forced means D won while P was also asking
  always_comb begin
    last_gnt_nxt   = last_gnt;
    forced_nxt     = g_d && bus.p_req;
    rd_tag_nxt     = TAG_NONE;
    starve_cnt_nxt = starve_cnt;

    if (!bus.p_req && !bus.d_req) begin
      last_gnt_nxt = IDLE;
    end else if (g_d) begin
      if (last_gnt == D_BURST)
        last_gnt_nxt = PIPE;
      else if (last_gnt == DBG && (forced_q || forced_nxt))
        last_gnt_nxt = D_BURST;
      else
        last_gnt_nxt = DBG;
    end else if (g_p) begin
      last_gnt_nxt = PIPE;
    end

    if (g_p && !bus.p_we)
      rd_tag_nxt = TAG_P;
    else if (g_d && !bus.d_we)
      rd_tag_nxt = TAG_D;

    if (!bus.d_req || g_d)
      starve_cnt_nxt = 8'd0;
    else if (starve_cnt != STARVE_LIM)
      starve_cnt_nxt = starve_cnt + 8'd1;

`ifdef DPORT_LOCK_EN
    if (lock_st == LOCKED)
      lock_nxt = bus.d_lock ? LOCKED : UNLOCKED;
    else
      lock_nxt = (g_d && bus.d_lock) ? LOCKED : UNLOCKED;
`endif
  end

  // Output logic: grants are held low while reset is asserted
  always_comb begin
    g_d = 1'b0;
    g_p = 1'b0;
    if (reset) begin
`ifdef DPORT_LOCK_EN
      g_d = bus.d_req && (lock_st == LOCKED || !bus.p_req ||
                          starve_cnt == STARVE_LIM || last_gnt == D_BURST);
      g_p = bus.p_req && !g_d && lock_st != LOCKED;
`else
      g_d = bus.d_req && (!bus.p_req || starve_cnt == STARVE_LIM || last_gnt == D_BURST);
      g_p = bus.p_req && !g_d;
`endif
    end
  end

  assign addr_mux      = g_d ? bus.d_addr : bus.p_addr;
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_be    = g_d ? bus.d_be : bus.p_be;
  assign bus.ram_wdata = g_d ? bus.d_wdata : bus.p_wdata;
  assign bus.ram_we    = (g_p && bus.p_we) || (g_d && bus.d_we);

  assign bus.p_stall   = reset && bus.p_req && !g_p;
  assign bus.d_gnt     = g_d;

  assign p_rvalid      = reset && (rd_tag == TAG_P);
  assign d_rvalid      = reset && (rd_tag == TAG_D);
  assign bus.p_rvalid  = p_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.p_rdata   = p_rvalid ? bus.ram_rdata : 32'd0;
  assign bus.d_rdata   = d_rvalid ? bus.ram_rdata : 32'd0;
endmodule

// File: tb/tb_rv32i_dport_arbiter.sv
// Directed bench for rv32i_dport_arbiter with a 1-cycle-latency byte-enabled RAM model.
// Compile with DPORT_LOCK_EN defined to also exercise the lock feature.
module tb_rv32i_dport_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  int   we_base;
  logic [31:0] mem [0:255];

  rv32i_dport_arbiter_if #(.ADDR_W(30)) bus ();

  rv32i_dport_arbiter #(.STARVE_MAX(4), .ADDR_W(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_we && bus.ram_be[b])
        mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    bus.ram_rdata <= mem[bus.ram_addr[7:0]];
    if (bus.ram_we) we_cnt <= we_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_p(input logic req, input logic we, input logic [29:0] addr, input logic [31:0] wdata);
    bus.p_req = req; bus.p_we = we; bus.p_be = 4'hF; bus.p_addr = addr; bus.p_wdata = wdata;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [29:0] addr, input logic [31:0] wdata);
    bus.d_req = req; bus.d_we = we; bus.d_be = 4'hF; bus.d_addr = addr; bus.d_wdata = wdata;
  endtask

  initial begin
    reset = 1'b0;
`ifdef DPORT_LOCK_EN
    bus.d_lock = 1'b0;
`endif
    set_p(1, 1, 30'h10, 32'h0);
    set_d(1, 1, 30'h10, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_d_gnt", bus.d_gnt, 0);
    check("rst_p_stall", bus.p_stall, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_p_rvalid", bus.p_rvalid, 0);
    check("rst_d_rvalid", bus.d_rvalid, 0);
    check("rst_p_rdata", bus.p_rdata, 0);

    // preload three words through P
    @(negedge clk); reset = 1'b1;
    set_p(1, 1, 30'h10, 32'hDEADBEEF); set_d(0, 0, 30'h0, 32'h0);
    #1 check("pre_p_stall", bus.p_stall, 0);
    check("pre_ram_we", bus.ram_we, 1);
    @(negedge clk); set_p(1, 1, 30'h4, 32'h44444444);
    @(negedge clk); set_p(1, 1, 30'h8, 32'h88888888);

    // P read only
    @(negedge clk); set_p(1, 0, 30'h10, 32'h0);
    #1 check("prd_p_stall", bus.p_stall, 0);
    check("prd_ram_we", bus.ram_we, 0);
    @(negedge clk); set_p(0, 0, 30'h10, 32'h0);
    #1 check("prd_p_rvalid", bus.p_rvalid, 1);
    check("prd_p_rdata", bus.p_rdata, 32'hDEADBEEF);
    check("prd_d_rvalid", bus.d_rvalid, 0);

    // contention: D refused 4 cycles, forced on the 5th
    @(negedge clk); set_p(1, 0, 30'h4, 32'h0); set_d(1, 0, 30'h8, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 check("cont_d_gnt_lo", bus.d_gnt, 0);
      check("cont_p_stall_lo", bus.p_stall, 0);
      @(negedge clk);
    end
    #1 check("cont_d_gnt_forced", bus.d_gnt, 1);
    check("cont_p_stall_hi", bus.p_stall, 1);
    check("cont_p_rdata", bus.p_rdata, 32'h44444444);
    // P drops for one cycle: D gets a second consecutive grant
    @(negedge clk); set_p(0, 0, 30'h4, 32'h0); set_d(1, 0, 30'h10, 32'h0);
    #1 check("cont_starve_clr", 32'(dut.starve_cnt), 0);
    check("cont_d_gnt2", bus.d_gnt, 1);
    check("cont_d_rdata", bus.d_rdata, 32'h88888888);
    check("cont_p_rvalid_stalled", bus.p_rvalid, 0);
    // burst cycle: D stays ahead of P once more
    @(negedge clk); set_p(1, 0, 30'h4, 32'h0); set_d(1, 0, 30'h4, 32'h0);
    #1 check("burst_d_gnt", bus.d_gnt, 1);
    check("burst_p_stall", bus.p_stall, 1);
    check("burst_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1 check("post_burst_d_gnt", bus.d_gnt, 0);
    check("post_burst_p_stall", bus.p_stall, 0);
    check("post_burst_d_rdata", bus.d_rdata, 32'h44444444);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0); set_d(0, 0, 30'h0, 32'h0);
    #1 check("post_burst_p_rdata", bus.p_rdata, 32'h44444444);
    check("post_burst_d_rvalid", bus.d_rvalid, 0);

    // interleaved single reads
    @(negedge clk); set_p(1, 0, 30'h4, 32'h0);
    #1 check("il_p_stall", bus.p_stall, 0);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0); set_d(1, 0, 30'h8, 32'h0);
    #1 check("il_d_gnt", bus.d_gnt, 1);
    check("il_p_rdata1", bus.p_rdata, 32'h44444444);
    check("il_d_rvalid1", bus.d_rvalid, 0);
    @(negedge clk); set_p(1, 0, 30'h8, 32'h0); set_d(0, 0, 30'h0, 32'h0);
    #1 check("il_p_rvalid2", bus.p_rvalid, 0);
    check("il_d_rdata2", bus.d_rdata, 32'h88888888);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0); set_d(1, 0, 30'h4, 32'h0);
    #1 check("il_p_rdata3", bus.p_rdata, 32'h88888888);
    check("il_d_rvalid3", bus.d_rvalid, 0);
    @(negedge clk); set_d(0, 0, 30'h0, 32'h0);
    #1 check("il_d_rdata4", bus.d_rdata, 32'h44444444);
    check("il_p_rvalid4", bus.p_rvalid, 0);

    // stalled P write must not commit; D write wins the forced slot
    @(negedge clk); set_p(1, 0, 30'h4, 32'h0); set_d(1, 1, 30'h20, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      #1 check("sw_ram_we_lo", bus.ram_we, 0);
      check("sw_d_gnt_lo", bus.d_gnt, 0);
      @(negedge clk);
    end
    set_p(1, 1, 30'h20, 32'h11111111); we_base = we_cnt;
    #1 check("sw_d_gnt", bus.d_gnt, 1);
    check("sw_p_stall", bus.p_stall, 1);
    check("sw_wdata_d", bus.ram_wdata, 32'h22222222);
    @(negedge clk); set_d(0, 0, 30'h0, 32'h0);
    #1 check("sw_p_stall_lo", bus.p_stall, 0);
    check("sw_ram_we_p", bus.ram_we, 1);
    check("sw_wdata_p", bus.ram_wdata, 32'h11111111);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0);
    #1 check("sw_we_pulses", 32'(we_cnt - we_base), 2);
    check("sw_mem", mem[8'h20], 32'h11111111);

    // same-address P write vs D read: D retries and sees the new data
    @(negedge clk); set_p(1, 1, 30'h24, 32'h5A5A5A5A); set_d(1, 0, 30'h24, 32'h0);
    #1 check("rw_d_gnt", bus.d_gnt, 0);
    check("rw_ram_we", bus.ram_we, 1);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0);
    #1 check("rw_d_gnt_retry", bus.d_gnt, 1);
    check("rw_ram_we_retry", bus.ram_we, 0);
    @(negedge clk); set_d(0, 0, 30'h0, 32'h0);
    #1 check("rw_d_rdata", bus.d_rdata, 32'h5A5A5A5A);

    // reset in the cycle after a granted D read
    @(negedge clk); set_d(1, 0, 30'h10, 32'h0);
    #1 check("mr_d_gnt", bus.d_gnt, 1);
    @(negedge clk); reset = 1'b0;
    set_p(1, 1, 30'h30, 32'h1); set_d(1, 1, 30'h30, 32'h2);
    #1 check("mr_d_rvalid", bus.d_rvalid, 0);
    check("mr_d_gnt_rst", bus.d_gnt, 0);
    check("mr_ram_we", bus.ram_we, 0);
    check("mr_d_rdata", bus.d_rdata, 0);
    @(negedge clk); reset = 1'b1;
    set_p(0, 0, 30'h0, 32'h0); set_d(0, 0, 30'h0, 32'h0);
    #1 check("mr_d_rvalid_rel", bus.d_rvalid, 0);
    check("mr_starve", 32'(dut.starve_cnt), 0);
    check("mr_last_gnt", 32'(dut.last_gnt), 0);
    @(negedge clk); set_p(1, 0, 30'h4, 32'h0); set_d(1, 0, 30'h8, 32'h0);
    #1 check("mr_d_gnt_after", bus.d_gnt, 0);
    check("mr_p_stall_after", bus.p_stall, 0);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0); set_d(0, 0, 30'h0, 32'h0);

`ifdef DPORT_LOCK_EN
    // lock: D takes the port, then holds it against P until d_lock drops
    @(negedge clk); bus.d_lock = 1'b1; set_d(1, 1, 30'h40, 32'hA0);
    #1 check("lk_d_gnt0", bus.d_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_p(1, 0, 30'h4, 32'h0); set_d(1, 1, 30'h41 + 30'(i), 32'hA1);
      #1 check("lk_p_stall", bus.p_stall, 1);
      check("lk_ram_we", bus.ram_we, 1);
    end
    @(negedge clk); bus.d_lock = 1'b0; set_d(0, 0, 30'h0, 32'h0);
    #1 check("lk_p_stall_release", bus.p_stall, 1);
    @(negedge clk);
    #1 check("lk_p_granted", bus.p_stall, 0);
    @(negedge clk); set_p(0, 0, 30'h0, 32'h0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
